// File: rtl/digi_ota_array.sv
// digi_ota_array: array of digital OTA channels, each in comparator or saturating-integrator mode.
module digi_ota_array #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 6,
  parameter int FILT     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [1:0]                gm,
  input  logic [CHANNELS-1:0]       vip,
  input  logic [CHANNELS-1:0]       vin,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       out_oe,
  output logic [CHANNELS*WIDTH-1:0] level,
  output logic [CHANNELS-1:0]       sat
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] MID = WIDTH'(1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] HI  = WIDTH'(3 << (WIDTH - 2));
  localparam logic [WIDTH-1:0] LO  = WIDTH'(1 << (WIDTH - 2));
  localparam logic [3:0]       FL  = 4'(FILT);
  localparam logic [1:0]       EQ  = 2'b00;
  localparam logic [1:0]       DN  = 2'b01;
  localparam logic [1:0]       UP  = 2'b10;
  logic [CHANNELS-1:0] p1_q, p2_q, n1_q, n2_q;
  logic                mode_q;
  logic [WIDTH:0]      step;
  assign step = (WIDTH+1)'(gm) + (WIDTH+1)'(1);
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (rst) begin
      p1_q <= '0;
      p2_q <= '0;
      n1_q <= '0;
      n2_q <= '0;
    end else begin
      p1_q <= vip;
      p2_q <= p1_q;
      n1_q <= vin;
      n2_q <= n1_q;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]       dec, cand_q, cand_d, qual_q, qual_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] lvl_q, lvl_d;
    logic [WIDTH:0]   sum;
    logic             out_q, out_d, oe_q, oe_d, sat_q, sat_d;
    always_comb begin
      dec    = (p2_q[c] == n2_q[c]) ? EQ : (p2_q[c] ? UP : DN);
      cand_d = dec;
      cnt_d  = (dec != cand_q) ? 4'd1 : (cnt_q >= FL) ? cnt_q : cnt_q + 4'd1;
      qual_d = (cnt_d >= FL) ? dec : qual_q;
      sum    = (qual_q == UP) ? {1'b0, lvl_q} + step : {1'b0, lvl_q} - step;
      // a carry or borrow out of the top bit means the step overshot a bound
      lvl_d  = (!mode || qual_q == EQ) ? lvl_q :
               sum[WIDTH] ? {WIDTH{qual_q == UP}} : sum[WIDTH-1:0];
      out_d  = mode ? ((lvl_d >= HI) ? 1'b1 : (lvl_d <= LO) ? 1'b0 : out_q)
                    : ((qual_q == UP) ? 1'b1 : (qual_q == DN) ? 1'b0 : out_q);
      oe_d   = mode || (qual_q != EQ);
      if (!en) begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        qual_d = qual_q;
        lvl_d  = lvl_q;
        out_d  = out_q;
        oe_d   = 1'b0;
      end
      if (mode != mode_q) begin
        lvl_d = MID;
        out_d = out_q;
      end
      sat_d = (lvl_d == '0) || (lvl_d == MAX);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        cand_q <= EQ;
        cnt_q  <= '0;
        qual_q <= EQ;
        lvl_q  <= MID;
        out_q  <= 1'b0;
        oe_q   <= 1'b0;
        sat_q  <= 1'b0;
      end else begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        qual_q <= qual_d;
        lvl_q  <= lvl_d;
        out_q  <= out_d;
        oe_q   <= oe_d;
        sat_q  <= sat_d;
      end
    end
    assign out[c]                   = out_q;
    assign out_oe[c]                = oe_q;
    assign sat[c]                   = sat_q;
    assign level[c*WIDTH +: WIDTH]  = lvl_q;
  end
endmodule

// File: doc/digi_ota_array.md
DIGI_OTA_ARRAY -- requirements
Module: digi_ota_array

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent OTA channels (1..8).
REQ-002 Parameter WIDTH, default 6: integrator level width in bits (4..12).
REQ-003 Parameter FILT, default 2: consecutive stable cycles needed to qualify an input state (1..15).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  channel-array enable; 0 freezes all state.
REQ-007 mode  input  1  0 = comparator mode, 1 = integrator (transconductance) mode.
REQ-008 gm  input  2  integrator step select; step = gm+1 (1..4).
REQ-009 vip  input  CHANNELS  non-inverting digital inputs, asynchronous.
REQ-010 vin  input  CHANNELS  inverting digital inputs, asynchronous.
REQ-011 out  output  CHANNELS  registered channel output value.
REQ-012 out_oe  output  CHANNELS  registered drive enable (0 = output high-Z/undriven).
REQ-013 level  output  CHANNELS*WIDTH  integrator level, channel c at bits [c*WIDTH +: WIDTH].
REQ-014 sat  output  CHANNELS  registered flag, 1 when level is 0 or 2^WIDTH-1.

Function
REQ-015 Each vip/vin bit SHALL pass through a 2-flop synchroniser before use.
REQ-016 Per channel, the synchronised pair SHALL decode to UP (vip=1,vin=0), DN (vip=0,vin=1) or EQ (vip=vin).
REQ-017 Filter: the qualified state SHALL change to a new decoded state only after that state has been present FILT consecutive cycles; any intervening change SHALL restart the count.
REQ-018 Latency: a new input pair held stable SHALL be reflected on out/out_oe/level exactly FILT+3 cycles after it is first applied.
REQ-019 Comparator mode, qualified UP: out=1, out_oe=1.
REQ-020 Comparator mode, qualified DN: out=0, out_oe=1.
REQ-021 Comparator mode, qualified EQ: out holds its last value, out_oe=0; level SHALL be unchanged.
REQ-022 Integrator mode: each cycle, UP adds step to level and DN subtracts step; EQ holds.
REQ-023 Integrator arithmetic SHALL saturate at 0 and 2^WIDTH-1 with no wrap-around; a step that would overshoot SHALL clip to the bound.
REQ-024 Integrator hysteresis: out SHALL go 1 when level >= 3*2^(WIDTH-2), go 0 when level <= 2^(WIDTH-2), and hold otherwise.
REQ-025 Integrator mode: out_oe SHALL be 1 for every channel.
REQ-026 sat SHALL be computed from the registered level and update with it.
REQ-027 mode change detected at a clock edge: level SHALL reload to midscale 2^(WIDTH-1) on that edge; out holds; filter state is kept.
REQ-028 gm changes SHALL take effect on the next integration step.
REQ-029 en=0: synchronisers keep sampling; filter, level, out and sat freeze; out_oe SHALL clear on the next edge.
REQ-030 en returning to 1: operation resumes from the frozen state; out_oe is re-evaluated on the next edge.
REQ-031 Channels SHALL be fully independent except for the shared en, mode and gm inputs.

Reset
REQ-032 rst=1 at an edge SHALL set all synchroniser flops to 0, qualified state to EQ and filter counts to 0.
REQ-033 rst=1 at an edge SHALL set level to 2^(WIDTH-1), out to 0, out_oe to 0 and sat to 0.
REQ-034 rst SHALL take priority over en and mode; reset mid-integration SHALL discard the level.

Verification (CHANNELS=2, WIDTH=6, FILT=2; midscale 32, HI 48, LO 16)
REQ-035 Reset: rst=1 for 2 cycles with arbitrary inputs -> out=00, out_oe=00, both levels=32, sat=00.
REQ-036 Comparator: mode=0, en=1, vip[0]=1, vin[0]=0 held -> out[0]=1, out_oe[0]=1 exactly 5 cycles later; then vip[0]=vin[0]=1 -> out_oe[0]=0 and out[0] still 1 after 5 cycles.
REQ-037 Glitch reject: channel 1 qualified DN, one-cycle vin[1]=0 pulse -> out[1], out_oe[1] and level[1] unchanged throughout.
REQ-038 Integrator ramp: mode=1, gm=3, channel 0 UP held -> level 36,40,44,48 on successive cycles; out[0]=1 when 48 is reached; then 52..60 and clips to 63; sat[0]=1 at 63.
REQ-039 Hysteresis: from level 63 with out=1, gm=0, DN held -> out[0] stays 1 through level 17 and goes 0 on the edge where level reaches 16.
REQ-040 Freeze/mode: en=0 mid-ramp at level 40 -> level holds at 40 and out_oe=00 next edge; mode toggled -> level reloads to 32 on that edge.
